dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave answering the core's load/store port (wr, rd, addr, wr_data) and returning load data on rd_data.
- Holds a byte-addressed word array.
- Applies RV32I sub-word store lane masking and load sign/zero extension from funct3.
- Flags misaligned or illegal accesses.
- Sits beside the core top, with its ports wired directly to the core's memory outputs.

Parameters:
- DATA_W, 32, data word width; only 32 supported.
- ADDR_W, 9, byte-address width; array depth is 2**(ADDR_W-2) words, 128 by default.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- wr  in  1  store request, sampled at the clk edge
- rd  in  1  load request, sampled at the clk edge
- addr  in  ADDR_W  byte address
- funct3  in  3  access size and signedness (RV32I encoding)
- wr_data  in  DATA_W  store data; the low bytes are used for SB/SH
- rd_data  out  DATA_W  extended load result, registered
- rd_valid  out  1  one-cycle pulse, rd_data valid
- err  out  1  one-cycle pulse, access rejected
- load_cnt  out  16  loads completed (optional feature)
- store_cnt  out  16  stores completed (optional feature)

Behaviour:
- Reset asserted (reset=0) at any time, including mid-access:
  - rd_data=0, rd_valid=0, err=0, counters=0, FSM->IDLE.
  - An in-flight load is dropped.
  - The array is not cleared.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- Stores take effect at the sampling edge; no response pulse unless err.
  - SB (000): write lane addr[1:0] with wr_data[7:0].
  - SH (001): write lanes {addr[1],0} and {addr[1],1} with wr_data[15:0].
  - SW (010): write all four lanes.
  - Untouched bytes are preserved (byte-enable write, no read-modify-write).
- Loads have 1-cycle latency:
  - Edge N samples rd; edge N+1 presents rd_data with rd_valid=1 for exactly one cycle.
  - LB 000: sign-extend byte. LH 001: sign-extend half. LW 010: word. LBU 100: zero-extend byte. LHU 101: zero-extend half.
  - Between accesses rd_data holds its last value; it is not zeroed.
- Back-to-back loads on consecutive cycles are legal: one result per cycle, in order.
- A load on the cycle after a store to the same word returns the new data.
- Error cases:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load with 011/110/111, or store with funct3>010.
  - wr and rd both high in the same cycle.
- On any error:
  - No array write.
  - err pulses at N+1, and rd_valid stays 0 at N+1.
  - rd_data is unchanged.
  - Counters do not increment.
- FSM is 2-state:
  - IDLE: any accepted load -> RESP; otherwise stay in IDLE.
  - RESP drives rd_valid; accepted load -> RESP, otherwise -> IDLE.
  - err is a separate one-cycle registered flag.
- Address bits above ADDR_W-1 are absent, so addresses wrap modulo 2**ADDR_W.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined:
  - load_cnt increments on each rd_valid pulse; store_cnt on each accepted store.
  - Both 16-bit, saturating at 16'hFFFF (no wrap).
  - Both cleared by reset.
- Undefined: load_cnt and store_cnt are tied to 0 and no counter flops exist. Port list is identical either way.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum dmem_state_t {IDLE, RESP}.
- One combinational sub-module, dmem_lane_ctrl: maps (funct3, addr[1:0], wr_data) to byte-enables[3:0], lane-aligned write word, and misalign/illegal flags.
- Extension of the registered read word is done in the top, using the registered funct3 and lane.

Test Plan:
- Reset: reset=0 mid-load at edge N -> no rd_valid at N+1; rd_data=0, err=0, counters=0.
- SW 0xDEADBEEF @0x010; LB @0x013 -> rd_data 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x010 -> 0xFFFFBEEF; LHU @0x012 -> 0x0000DEAD.
- SW 0x11223344 @0x020, SB 0xAA @0x021, SH 0x5566 @0x022; LW @0x020 -> 0x5566AA44.
- Misaligned/illegal cases:
  - LW @0x021 -> err pulse, no rd_valid, rd_data unchanged.
  - SH @0x023 -> err pulse, word unchanged.
  - wr=rd=1 -> err pulse.
- Three back-to-back LWs @0x000/0x004/0x008 after SWs of 1/2/3 -> rd_valid high 3 consecutive cycles, data 1,2,3.
- DMEM_STATS_EN: 70000 LWs -> load_cnt saturates at 0xFFFF; 5 stores plus 1 erroneous store -> store_cnt=5.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder. It holds
//               the RV32I load/store funct3 encodings and the response FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_ctrl
// Description : Combinational lane decoder for the data-memory responder.
//               Maps funct3 and the byte lane to store byte-enables and a
//               lane-replicated write word. It also flags misaligned
//               accesses and illegal funct3 codes for the request type.
// Ports       : i_funct3    - access size / signedness
//               i_lane      - addr[1:0]
//               i_is_store  - 1 = store request, 0 = load request
//               i_wr_data   - raw store data (low bytes used for SB/SH)
//               o_be        - per-lane byte enables
//               o_wdata     - write word with data replicated into lanes
//               o_misalign  - access not naturally aligned
//               o_illegal   - funct3 not legal for this request type
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic        i_is_store,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic        o_illegal
);

    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wr_data;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;

        // Size is funct3[1:0] for both loads and stores.
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wr_data[7:0]}};
            end
            2'b01: begin
                o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wr_data[15:0]}};
                o_misalign = i_lane[0];
            end
            2'b10: begin
                o_be       = 4'b1111;
                o_misalign = (i_lane != 2'b00);
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase

        // Stores have no unsigned variants; loads reject 011/110/111.
        if (i_is_store) begin
            o_illegal = (i_funct3 > F3_W);
        end else begin
            o_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                        (i_funct3 == 3'b111);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory slave for the core load/store port. It holds a
//               byte-addressed word array with byte-enable writes and
//               returns loads one cycle later with RV32I sign or zero
//               extension. Misaligned or illegal accesses raise a
//               one-cycle err pulse and have no other effect.
//               Optional macro DMEM_STATS_EN enables the saturating
//               load/store counters. When it is undefined the counter
//               ports read as zero.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               wr, rd    - store / load request
//               addr      - byte address
//               funct3    - RV32I access size / signedness
//               wr_data   - store data
//               rd_data   - extended load result
//               rd_valid  - one-cycle pulse, rd_data valid
//               err       - one-cycle pulse, access rejected
//               load_cnt  - loads completed (stats build)
//               store_cnt - stores completed (stats build)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt
);

    localparam int c_DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [ADDR_W-3:0] w_idx;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_bad;
    logic              w_ld_ok;
    logic              w_st_ok;
    logic              w_err_req;

    dmem_state_t       r_state;
    logic              r_err;
    logic [DATA_W-1:0] r_word;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_idx = addr[ADDR_W-1:2];

    dmem_lane_ctrl u_lane_ctrl (
        .i_funct3   (funct3),
        .i_lane     (addr[1:0]),
        .i_is_store (wr),
        .i_wr_data  (wr_data),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign w_bad     = w_misalign | w_illegal;
    assign w_ld_ok   = rd & ~wr & ~w_bad;
    assign w_st_ok   = wr & ~rd & ~w_bad;
    assign w_err_req = (wr & rd) | ((wr | rd) & w_bad);

    // The array has no reset, so its contents survive reset.
    always_ff @(posedge clk) begin
        if (w_st_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response FSM. The raw word, funct3 and lane are captured only on an
    // accepted load, so rd_data holds its value between loads and on errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_word  <= '0;
            r_f3    <= F3_W;
            r_lane  <= 2'b00;
        end else begin
            r_err <= w_err_req;
            if (w_ld_ok) begin
                r_word <= r_mem[w_idx];
                r_f3   <= funct3;
                r_lane <= addr[1:0];
            end
            case (r_state)
                IDLE:    r_state <= w_ld_ok ? RESP : IDLE;
                RESP:    r_state <= w_ld_ok ? RESP : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_valid = (r_state == RESP);
    assign err      = r_err;

    // Extension works on registered state only, so rd_data is glitch-free
    // and reads as zero after reset.
    assign w_byte = r_word[{r_lane, 3'b000} +: 8];
    assign w_half = r_word[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        rd_data = r_word;
        case (r_f3)
            F3_B:    rd_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_H:    rd_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_BU:   rd_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_HU:   rd_data = {{(DATA_W-16){1'b0}}, w_half};
            default: rd_data = r_word;
        endcase
    end

`ifdef DMEM_STATS_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    // The load count steps on the edge that raises rd_valid, so it already
    // includes the pulse currently being presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_cnt  <= 16'h0000;
            r_store_cnt <= 16'h0000;
        end else begin
            if (w_ld_ok && (r_load_cnt != 16'hFFFF)) begin
                r_load_cnt <= r_load_cnt + 16'h0001;
            end
            if (w_st_ok && (r_store_cnt != 16'hFFFF)) begin
                r_store_cnt <= r_store_cnt + 16'h0001;
            end
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
`else
    assign load_cnt  = 16'h0000;
    assign store_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A byte-array model
//               of memory and the RV32I load/store rules supplies every
//               expected rd_data, rd_valid, err and counter value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m [512];
    logic [31:0] e_rd = '0;
    logic        e_valid = 1'b0;
    logic        e_err = 1'b0;
    int          e_lc = 0;
    int          e_sc = 0;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .funct3    (funct3),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
    );

    always #5 clk = ~clk;

    function automatic int acc_bytes(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic w, input logic r,
                                       input logic [8:0] a, input logic [2:0] f);
        int n;
        if (!w && !r) return 1'b0;
        if (w && r) return 1'b1;
        if (r && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
        if (w && f > 3'd2) return 1'b1;
        n = acc_bytes(f);
        return (int'(a) % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
        int n;
        int v;
        n = acc_bytes(f);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (int'(m[(int'(a) + i) % 512]) << (8 * i));
        if (!f[2] && n == 1 && v >= 128) v = v - 256;
        if (!f[2] && n == 2 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    task automatic do_op(input logic w, input logic r, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        logic bad;
        @(negedge clk);
        wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
        @(posedge clk);
        #1;
        bad = model_err(w, r, a, f);
        e_err = bad;
        e_valid = r && !bad;
        if (w && !bad) begin
            for (int i = 0; i < acc_bytes(f); i++) m[(int'(a) + i) % 512] = d[8*i +: 8];
            if (e_sc < 65535) e_sc++;
        end
        if (e_valid) begin
            e_rd = model_load(a, f);
            if (e_lc < 65535) e_lc++;
        end
    endtask

    task automatic idle();
        do_op(1'b0, 1'b0, 9'h0, 3'd0, 32'h0);
    endtask

    task automatic model_reset();
        e_rd = '0; e_valid = 1'b0; e_err = 1'b0; e_lc = 0; e_sc = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (rd_data !== 32'h0 || rd_valid !== 1'b0 || err !== 1'b0 ||
            load_cnt !== 16'h0 || store_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: rd_data=%h rd_valid=%b err=%b lc=%h sc=%h required all 0",
                     rd_data, rd_valid, err, load_cnt, store_cnt);
        end
        @(negedge clk); reset = 1'b1;
        // Fill every word so that all later loads are defined.
        for (int i = 0; i < 128; i++) do_op(1'b1, 1'b0, 9'(i * 4), 3'd2, $urandom);
        // Accept a load, then reset before the response cycle ends.
        do_op(1'b0, 1'b1, 9'h004, 3'd2, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e_rd) begin
            failures++;
            $display("FAIL reset_preload: rd_valid=%b rd_data=%h required 1 %h", rd_valid, rd_data, e_rd);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || err !== 1'b0 ||
            load_cnt !== 16'h0 || store_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_midload: rd_valid=%b rd_data=%h err=%b lc=%h sc=%h required 0",
                     rd_valid, rd_data, err, load_cnt, store_cnt);
        end
        // A load presented while reset is held must not respond.
        do_op(1'b0, 1'b1, 9'h008, 3'd2, 32'h0);
        e_valid = 1'b0; e_rd = '0; e_lc = 0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_held_load: rd_valid=%b rd_data=%h required 0 0", rd_valid, rd_data);
        end
        @(negedge clk); reset = 1'b1; rd = 1'b0;
    endtask

    task automatic test_ext();
        logic [31:0] req [4];
        logic [8:0]  la  [4];
        logic [2:0]  lf  [4];
        req[0] = 32'hFFFFFFDE; la[0] = 9'h013; lf[0] = 3'b000;
        req[1] = 32'h000000DE; la[1] = 9'h013; lf[1] = 3'b100;
        req[2] = 32'hFFFFBEEF; la[2] = 9'h010; lf[2] = 3'b001;
        req[3] = 32'h0000DEAD; la[3] = 9'h012; lf[3] = 3'b101;
        do_op(1'b1, 1'b0, 9'h010, 3'd2, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 1'b1, la[i], lf[i], 32'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== req[i] || e_rd !== req[i]) begin
                failures++;
                $display("FAIL ext_%0d: rd_valid=%b rd_data=%h required 1 %h", i, rd_valid, rd_data, req[i]);
            end
        end
        do_op(1'b1, 1'b0, 9'h020, 3'd2, 32'h11223344);
        do_op(1'b1, 1'b0, 9'h021, 3'd0, 32'hFFFFFFAA);
        do_op(1'b1, 1'b0, 9'h022, 3'd1, 32'hFFFF5566);
        do_op(1'b0, 1'b1, 9'h020, 3'd2, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h5566AA44) begin
            failures++;
            $display("FAIL merge_lanes: rd_valid=%b rd_data=%h required 1 5566aa44", rd_valid, rd_data);
        end
        idle();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h5566AA44) begin
            failures++;
            $display("FAIL hold_data: rd_valid=%b rd_data=%h required 0 5566aa44", rd_valid, rd_data);
        end
    endtask

    task automatic test_errors();
        do_op(1'b0, 1'b1, 9'h021, 3'd2, 32'h0);
        checks++;
        if (err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h5566AA44) begin
            failures++;
            $display("FAIL err_lw_misalign: err=%b rd_valid=%b rd_data=%h required 1 0 5566aa44",
                     err, rd_valid, rd_data);
        end
        idle();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle: err=%b required 0", err);
        end
        do_op(1'b1, 1'b0, 9'h023, 3'd1, 32'h0000BBCC);
        checks++;
        if (err !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_sh_misalign: err=%b rd_valid=%b required 1 0", err, rd_valid);
        end
        do_op(1'b1, 1'b1, 9'h020, 3'd2, 32'h12345678);
        checks++;
        if (err !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_wr_rd: err=%b rd_valid=%b required 1 0", err, rd_valid);
        end
        for (int f = 3; f < 8; f++) begin
            do_op(1'b1, 1'b0, 9'h020, 3'(f), 32'hCAFEF00D);
            checks++;
            if (err !== 1'b1) begin
                failures++;
                $display("FAIL err_st_f3_%0d: err=%b required 1", f, err);
            end
        end
        do_op(1'b0, 1'b1, 9'h020, 3'd2, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || err !== 1'b0 || rd_data !== 32'h5566AA44) begin
            failures++;
            $display("FAIL err_word_intact: rd_valid=%b err=%b rd_data=%h required 1 0 5566aa44",
                     rd_valid, err, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 1'b0, 9'h000, 3'd2, 32'd1);
        do_op(1'b1, 1'b0, 9'h004, 3'd2, 32'd2);
        do_op(1'b1, 1'b0, 9'h008, 3'd2, 32'd3);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 1'b1, 9'(4 * i), 3'd2, 32'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'(i + 1)) begin
                failures++;
                $display("FAIL b2b_%0d: rd_valid=%b rd_data=%h required 1 %h", i, rd_valid, rd_data, i + 1);
            end
        end
        // Store then immediately load the same word.
        do_op(1'b1, 1'b0, 9'h044, 3'd0, 32'h0000007F);
        do_op(1'b0, 1'b1, 9'h044, 3'd0, 32'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0000007F) begin
            failures++;
            $display("FAIL st_then_ld: rd_valid=%b rd_data=%h required 1 0000007f", rd_valid, rd_data);
        end
        idle();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_random();
        logic w, r;
        int sel;
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            w = (sel < 4) || (sel == 9);
            r = (sel >= 4 && sel < 8) || (sel == 9);
            // Bias addresses toward alignment so most accesses are accepted.
            do_op(w, r, ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom) & 9'h1FC,
                  ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
                  $urandom);
            checks++;
            if (rd_valid !== e_valid || err !== e_err || rd_data !== e_rd) begin
                failures++;
                $display("FAIL random_%0d: valid=%b err=%b data=%h required %b %b %h",
                         k, rd_valid, err, rd_data, e_valid, e_err, e_rd);
            end
            checks++;
`ifdef DMEM_STATS_EN
            if (load_cnt !== 16'(e_lc) || store_cnt !== 16'(e_sc)) begin
`else
            if (load_cnt !== 16'h0 || store_cnt !== 16'h0) begin
`endif
                failures++;
                $display("FAIL random_cnt_%0d: lc=%h sc=%h required %h %h", k, load_cnt, store_cnt,
                         16'(e_lc), 16'(e_sc));
            end
        end
    endtask

    task automatic test_stats();
        @(negedge clk); reset = 1'b0; wr = 1'b0; rd = 1'b0;
        model_reset();
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 9'(8 * i), 3'd2, $urandom);
        do_op(1'b1, 1'b0, 9'h002, 3'd2, 32'h0);
        idle();
        checks++;
`ifdef DMEM_STATS_EN
        if (store_cnt !== 16'd5 || e_sc != 5) begin
            failures++;
            $display("FAIL stats_store_cnt: store_cnt=%0d required 5", store_cnt);
        end
        for (int i = 0; i < 70000; i++) do_op(1'b0, 1'b1, 9'h000, 3'd2, 32'h0);
        idle();
        checks++;
        if (load_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_load_sat: load_cnt=%h required ffff", load_cnt);
        end
`else
        if (store_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stats_store_off: store_cnt=%0d required 0", store_cnt);
        end
        for (int i = 0; i < 20; i++) do_op(1'b0, 1'b1, 9'h000, 3'd2, 32'h0);
        checks++;
        if (load_cnt !== 16'h0) begin
            failures++;
            $display("FAIL stats_load_off: load_cnt=%h required 0", load_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ext();
        test_errors();
        test_back_to_back();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
